hazard_unit: RTL and testbench

- Consumes the per-instruction control bundle and isJump flag produced in ID, together with the control bundle of the instruction in EX.
- Generates pipeline hold, flush and bubble controls:
  - detects load-use hazards (one-cycle stall);
  - after a branch or jump issues, holds fetch and injects NOPs until the MEM stage reports resolution.
- Sits beside the IF/ID and ID/EX pipeline registers. Drives PC write-enable, IF/ID write/flush and the ID/EX control-zeroing mux.

---
 rtl/hazard_unit.sv | 96 +++++++++
 tb/tb_hazard_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall plus branch/jump fetch hold until MEM resolves.
// Drives PC enable, IF/ID write/flush and the ID/EX control-zeroing bubble.
module hazard_unit #(
    parameter int CONTROL_SIZE = 8,
    parameter int RESOLVE_LAT  = 2,
    parameter int CNT_W        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CONTROL_SIZE-1:0] idControl,
    input  logic                    idIsJump,
    input  logic [4:0]              idRs,
    input  logic [4:0]              idRt,
    input  logic                    idUsesRt,
    input  logic [CONTROL_SIZE-1:0] exControl,
    input  logic [4:0]              exRt,
    input  logic                    branchDone,
    output logic                    pcWrite,
    output logic                    ifIdWrite,
    output logic                    ifIdFlush,
    output logic                    idExBubble,
    output logic                    resolveErr,
    output logic [CNT_W-1:0]        stallCycles
);

    typedef enum logic {RUN, BR_WAIT} state_t;

    localparam logic [1:0] LAT = 2'(RESOLVE_LAT);

    state_t     state;
    logic [1:0] cnt;
    logic       loadUse;
    logic       isBr;
    logic       unused_ctl;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign loadUse = exControl[3] & (exRt != 5'd0) &
                     ((exRt == idRs) | (idUsesRt & (exRt == idRt)));
    assign isBr    = idControl[5] | idIsJump;

    // Only MemRead of EX and Branch of ID matter for hazard decisions.
    assign unused_ctl = ^{idControl, exControl};

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        if (state == BR_WAIT) begin
            pcWrite    = branchDone;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (loadUse) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            cnt         <= 2'd0;
            resolveErr  <= 1'b0;
            stallCycles <= '0;
        end else begin
            if (!pcWrite)
                stallCycles <= sat_inc(stallCycles);
            case (state)
                RUN: begin
                    // A pending load-use stall holds the branch in ID; it issues next cycle.
                    if (!loadUse && isBr) begin
                        state <= BR_WAIT;
                        cnt   <= LAT;
                    end
                end
                BR_WAIT: begin
                    if (branchDone) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 2'd1;
                        if (cnt == 2'd1) begin
                            resolveErr <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a cycle-level reference model.
module tb_hazard_unit;

    localparam int CS = 8;
    localparam int RL = 2;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [CS-1:0] idControl, exControl;
    logic          idIsJump, idUsesRt, branchDone;
    logic [4:0]    idRs, idRt, exRt;
    logic          pcWrite, ifIdWrite, ifIdFlush, idExBubble, resolveErr;
    logic [CW-1:0] stallCycles;

    int checks = 0;
    int errors = 0;

    // Reference model state: waiting flag, cycles already spent waiting, sticky error, stall count
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_stalls;
    bit e_pc, e_ifw, e_fl, e_bub, e_lu;

    hazard_unit #(.CONTROL_SIZE(CS), .RESOLVE_LAT(RL), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .idControl(idControl), .idIsJump(idIsJump), .idRs(idRs), .idRt(idRt),
        .idUsesRt(idUsesRt), .exControl(exControl), .exRt(exRt),
        .branchDone(branchDone),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExBubble(idExBubble), .resolveErr(resolveErr), .stallCycles(stallCycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait   = 0;
        m_waited = 0;
        m_err    = 0;
        m_stalls = 0;
    endtask

    task automatic idle();
        idControl  = '0;
        exControl  = '0;
        idIsJump   = 1'b0;
        idUsesRt   = 1'b0;
        branchDone = 1'b0;
        idRs       = 5'd0;
        idRt       = 5'd0;
        exRt       = 5'd0;
    endtask

    task automatic predict();
        e_lu = exControl[3] && exRt != 5'd0 &&
               (exRt == idRs || (idUsesRt && exRt == idRt));
        if (m_wait) begin
            e_pc = branchDone; e_ifw = 1; e_fl = 1; e_bub = 1;
        end else if (e_lu) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
        end
    endtask

    // Check outputs mid-cycle, then advance the model across the rising edge.
    task automatic tick();
        @(negedge clock);
        predict();
        chk("pcWrite", 32'(pcWrite), 32'(e_pc));
        chk("ifIdWrite", 32'(ifIdWrite), 32'(e_ifw));
        chk("ifIdFlush", 32'(ifIdFlush), 32'(e_fl));
        chk("idExBubble", 32'(idExBubble), 32'(e_bub));
        chk("resolveErr", 32'(resolveErr), 32'(m_err));
        chk("stallCycles", 32'(stallCycles), 32'(m_stalls));
        @(posedge clock);
        if (reset) begin
            if (!e_pc && m_stalls < (1 << CW) - 1)
                m_stalls++;
            if (m_wait) begin
                if (branchDone) begin
                    m_wait = 0;
                end else begin
                    m_waited++;
                    if (m_waited == RL) begin
                        m_err  = 1;
                        m_wait = 0;
                    end
                end
            end else if (!e_lu && (idControl[5] || idIsJump)) begin
                m_wait   = 1;
                m_waited = 0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("post_reset_stalls", 32'(stallCycles), 32'd0);

        // Load-use on rs, then non-hazard variants
        exControl = 8'b11001000; exRt = 5'd5; idRs = 5'd5;
        tick();
        idle();
        tick();
        chk("lu_one_stall", 32'(stallCycles), 32'd1);
        exControl = 8'b11001000; exRt = 5'd5; idRs = 5'd6; idRt = 5'd5; idUsesRt = 1'b0;
        tick();
        exRt = 5'd0; idRs = 5'd0;
        tick();
        chk("lu_no_stall", 32'(stallCycles), 32'd1);
        exRt = 5'd5; idRs = 5'd6; idRt = 5'd5; idUsesRt = 1'b1;
        tick();
        chk("lu_rt_stall", 32'(stallCycles), 32'd2);

        // Jump resolved two cycles after issue
        apply_reset();
        idControl = 8'b10000100; idIsJump = 1'b1;
        tick();
        idle();
        #1 chk("jmp_wait_pc", 32'(pcWrite), 32'd0);
        chk("jmp_wait_flush", 32'(ifIdFlush), 32'd1);
        tick();
        branchDone = 1'b1;
        #1 chk("jmp_done_pc", 32'(pcWrite), 32'd1);
        tick();
        branchDone = 1'b0;
        tick();
        chk("jmp_stalls", 32'(stallCycles), 32'd1);

        // Branch and load-use in the same cycle
        apply_reset();
        idControl = 8'b00100000; exControl = 8'b00001000; exRt = 5'd3; idRs = 5'd3;
        tick();
        exControl = '0;
        tick();
        idControl = '0;
        tick();
        branchDone = 1'b1;
        tick();
        branchDone = 1'b0;
        tick();
        chk("brlu_stalls", 32'(stallCycles), 32'd2);

        // Watchdog expiry
        apply_reset();
        idControl = 8'b00100000;
        tick();
        idle();
        tick();
        tick();
        chk("wd_err", 32'(resolveErr), 32'd1);
        tick();
        tick();
        chk("wd_err_sticky", 32'(resolveErr), 32'd1);
        chk("wd_stalls", 32'(stallCycles), 32'd2);

        // Reset asserted during the branch wait
        idControl = 8'b00100000;
        tick();
        idle();
        #2 chk("mid_wait_pc", 32'(pcWrite), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_async_pc", 32'(pcWrite), 32'd1);
        chk("rst_async_flush", 32'(ifIdFlush), 32'd0);
        chk("rst_async_bubble", 32'(idExBubble), 32'd0);
        chk("rst_async_err", 32'(resolveErr), 32'd0);
        chk("rst_async_stalls", 32'(stallCycles), 32'd0);
        model_reset();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_release_stalls", 32'(stallCycles), 32'd0);

        // Randomized traffic against the model, long enough to saturate the counter
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            exControl  = CS'($urandom);
            idControl  = CS'($urandom) & ~CS'(32);
            if ($urandom_range(3) == 0) idControl[5] = 1'b1;
            idIsJump   = ($urandom_range(7) == 0);
            idUsesRt   = 1'($urandom);
            idRs       = 5'($urandom_range(3));
            idRt       = 5'($urandom_range(3));
            exRt       = 5'($urandom_range(3));
            branchDone = ($urandom_range(2) == 0);
            tick();
        end
        chk("rand_saturated", 32'(stallCycles), 32'((1 << CW) - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
